instr_splitter: RTL
===================

INSTR_SPLITTER -- requirements
Module: instr_splitter

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 IRDY  input  1  prefetcher holds a bundle on IBUS/VF.
REQ-005 VF  input  4  per-slot valid flags of the bundle; slot k is IBUS[16k+15:16k].
REQ-006 IBUS  input  64  instruction bundle, four 16-bit slots.
REQ-007 IFETCH  output  1  bundle consume strobe to prefetcher (combinational).
REQ-008 FLUSH  input  1  near-jump restart (ERST); discard all held slots.
REQ-009 ITAKE  input  1  sequencer accepts current instruction.
REQ-010 IVALID  output  1  INSTR holds a valid instruction.
REQ-011 INSTR  output  32  current instruction; bits 31:16 zero for short form.
REQ-012 LONG  output  1  INSTR is a two-slot long-JC instruction.
REQ-013 SLOTS  output  2  slots retired by the current instruction (1 or 2); 0 when IVALID=0.
REQ-014 INSTCNT  output  16  count of retired instructions, wraps.

Function
REQ-015 State SHALL be a bundle register S[3:0] (16 bits each), valid vector BV[3:0], and INSTCNT.
REQ-016 Head index h SHALL be the lowest k with BV[k]=1; IVALID SHALL equal |BV.
REQ-017 Slot h SHALL be long-JC when S[h][3:0]=4'h2, S[h][15:12]=4'h1, and h is 0 or 2.
REQ-018 For long-JC: INSTR={S[h+1],S[h]}, LONG=1, SLOTS=2, independent of BV[h+1] (the prefetcher clears that flag).
REQ-019 Otherwise: INSTR={16'h0,S[h]}, LONG=0, SLOTS=1.
REQ-020 When IVALID=0: INSTR=0, LONG=0, SLOTS=0.
REQ-021 Retire SHALL occur on ITAKE & IVALID & ~FLUSH.
  - clears BV[h]; for long, also BV[h+1].
  - INSTCNT+1 modulo 2^16.
  - ITAKE with IVALID=0 is ignored.
REQ-022 Let R = BV after the same-cycle retire mask. IFETCH SHALL be ~FLUSH & (R==4'b0000), giving back-to-back bundles without a bubble.
REQ-023 Load SHALL occur on IRDY & IFETCH: S<=IBUS, BV<=VF; the load overrides the retire update of BV.
REQ-024 A loaded bundle with VF=0 SHALL leave IVALID=0 and IFETCH=1 the next cycle.
REQ-025 Latency: a bundle accepted at edge n SHALL present IVALID and INSTR from edge n+1.
REQ-026 FLUSH=1 SHALL:
  - force IFETCH=0;
  - set BV<=0 at the edge;
  - suppress load and retire; INSTCNT does not increment.
REQ-027 FLUSH held for multiple cycles SHALL keep BV=0; normal fetch resumes the cycle FLUSH drops.
REQ-028 Outputs SHALL depend only on registered state, except IFETCH, which also depends on ITAKE and FLUSH.

Reset
REQ-029 RESET=0 SHALL asynchronously clear BV, S and INSTCNT.
  - During reset: IVALID=0, INSTR=0, LONG=0, SLOTS=0, INSTCNT=0, IFETCH=0 (IFETCH gated by internal reset).
REQ-030 The first IFETCH=1 SHALL occur after the first CLK edge following RESET deassertion.
REQ-031 Reset asserted mid-bundle SHALL discard all slots; no partial instruction is presented after reset.

Verification
REQ-032 Short bundle: IRDY=1, VF=4'hF, IBUS=64'h0004_0003_0001_0000.
  - ITAKE held high: INSTR=0000, 0001, 0003, 0004 on consecutive cycles; SLOTS=1 each.
  - IFETCH=1 in the fourth cycle; INSTCNT=4.
REQ-033 Long-JC at slot 0: VF=4'b1101, IBUS slot0=16'h1002, slot1=16'hABCD.
  - First instruction INSTR=32'hABCD1002, LONG=1, SLOTS=2; next instruction is slot 2.
REQ-034 Long-JC at slot 2: VF=4'b0111, slot2=16'h1F02, slot3=16'h0055.
  - Third instruction INSTR=32'h00551F02, LONG=1; IFETCH=1 in the same cycle as that take.
REQ-035 FLUSH with 3 slots pending and IRDY=1:
  - that cycle IFETCH=0, no retire.
  - next cycle IVALID=0, INSTCNT unchanged.
  - following cycle IFETCH=1 and the new bundle loads.
REQ-036 Stall: ITAKE=0 for 10 cycles with a bundle held.
  - INSTR is stable, IFETCH=0, and the prefetcher bundle is not consumed.
REQ-037 Wrap and reset:
  - Preload INSTCNT to 16'hFFFF via 65535 retires; one more retire gives INSTCNT=0.
  - RESET=0 mid-cycle forces IVALID=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_splitter.sv
// Splits 4-slot prefetch bundles into short (1-slot) and long-JC (2-slot)
// instructions; tracks retired-instruction count.
//
// Ports:
//   CLK, RESET          clock, async active-low reset
//   IRDY, VF, IBUS      prefetcher bundle offer (4 x 16-bit slots + valids)
//   IFETCH              combinational bundle consume strobe
//   FLUSH               restart: drop all held slots
//   ITAKE               sequencer accepts current instruction
//   IVALID, INSTR,
//   LONG, SLOTS         current instruction view
//   INSTCNT             retired-instruction count (wraps)
module instr_splitter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IRDY,
    input  logic [3:0]  VF,
    input  logic [63:0] IBUS,
    output logic        IFETCH,
    input  logic        FLUSH,
    input  logic        ITAKE,
    output logic        IVALID,
    output logic [31:0] INSTR,
    output logic        LONG,
    output logic [1:0]  SLOTS,
    output logic [15:0] INSTCNT
);

    logic [3:0][15:0] slot_q, slot_d;
    logic [3:0]       bv_q, bv_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             run_q;

    logic [1:0]  head;
    logic [1:0]  head_nx;
    logic [15:0] head_w;
    logic [15:0] next_w;
    logic        is_long;
    logic        retire;
    logic [3:0]  ret_mask;
    logic [3:0]  rem;
    logic        load;

    // Lowest valid slot is the head.
    always_comb begin
        head = 2'd3;
        if (bv_q[0])
            head = 2'd0;
        else if (bv_q[1])
            head = 2'd1;
        else if (bv_q[2])
            head = 2'd2;
    end

    assign head_nx = head + 2'd1;
    assign head_w  = slot_q[head];
    assign next_w  = slot_q[head_nx];
    assign IVALID  = |bv_q;

    // Long-JC may only start on an even slot so its tail stays in-bundle.
    assign is_long = IVALID
                   & ~head[0]
                   & (head_w[3:0] == 4'h2)
                   & (head_w[15:12] == 4'h1);

    always_comb begin
        INSTR = 32'h0;
        LONG  = 1'b0;
        SLOTS = 2'd0;
        if (IVALID) begin
            if (is_long) begin
                INSTR = {next_w, head_w};
                LONG  = 1'b1;
                SLOTS = 2'd2;
            end else begin
                INSTR = {16'h0, head_w};
                SLOTS = 2'd1;
            end
        end
    end

    assign retire = ITAKE & IVALID & ~FLUSH;

    always_comb begin
        ret_mask = 4'b0001 << head;
        if (is_long)
            ret_mask = ret_mask | (4'b0010 << head);
    end

    assign rem = retire ? (bv_q & ~ret_mask) : bv_q;

    // Fetch as soon as this cycle's retire empties the register,
    // so bundles stream back-to-back. run_q holds it off until the
    // first edge after reset release.
    assign IFETCH = run_q & ~FLUSH & (rem == 4'b0000);
    assign load   = IRDY & IFETCH;

    always_comb begin
        slot_d = slot_q;
        bv_d   = rem;
        cnt_d  = cnt_q;
        if (retire)
            cnt_d = cnt_q + 16'd1;
        if (FLUSH) begin
            bv_d = 4'b0000;
        end else if (load) begin
            slot_d = IBUS;
            bv_d   = VF;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            slot_q <= '0;
            bv_q   <= 4'b0000;
            cnt_q  <= 16'h0;
            run_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            bv_q   <= bv_d;
            cnt_q  <= cnt_d;
            run_q  <= 1'b1;
        end
    end

    assign INSTCNT = cnt_q;

endmodule
